// File: rtl/sw_pio_pkg.sv
// Shared constants for the switch PIO with interrupt.
// Register addresses and edge-mode encodings.
package sw_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/sw_debounce.sv
// Single-bit synchroniser followed by a stable-level debounce counter.
// The level is accepted after DEBOUNCE_CYCLES consecutive differing cycles.
module sw_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   s;

  assign s   = sync_q[SYNC_STAGES-1];
  assign deb = deb_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = '0;
    deb_d  = deb_q;
    if (s != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

endmodule

// File: rtl/sw_pio_irq.sv
// Debounced switch PIO with mask / edge-capture registers and level irq.
// Avalon-MM slave, read latency 1, readdata refreshed every cycle.
module sw_pio_irq
  import sw_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rise, fall, sel_edge, w1c;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .deb    (deb[i])
    );
  end

  assign rise     = deb & ~deb_dly_q;
  assign fall     = ~deb & deb_dly_q;
  assign wr       = chipselect & ~write_n;
  assign readdata = rd_q;
  assign irq      = irq_q;

  always_comb begin
    sel_edge = rise;
    if (EDGE_MODE == EDGE_FALL) begin
      sel_edge = fall;
    end else if (EDGE_MODE == EDGE_BOTH) begin
      sel_edge = rise | fall;
    end
  end

  always_comb begin
    mask_d = mask_q;
    w1c    = '0;
    if (wr && address == ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr && address == ADDR_EDGE) begin
      w1c = writedata[WIDTH-1:0];
    end
    // a new edge wins over a same-cycle clear
    edge_d = (edge_q & ~w1c) | sel_edge;
    irq_d  = |(edge_q & mask_q);
  end

  always_comb begin
    rd_d = '0;
    unique case (address)
      ADDR_DATA: rd_d[WIDTH-1:0] = deb;
      ADDR_RSVD: rd_d = '0;
      ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[WIDTH-1:0] = edge_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      deb_dly_q <= deb;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      rd_q      <= rd_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: doc/sw_pio_irq.md
Name: sw_pio_irq

Overview:
Parametrised successor of the switch input PIO, sitting on the HPS lightweight Avalon-MM bridge. Samples WIDTH asynchronous switch/button inputs through a synchroniser and per-bit debouncer. Exposes three registers: debounced data, interrupt mask, and edge capture. Raises a level interrupt to the HPS on masked, captured edges.

Parameters:
WIDTH, 4, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (>=1; 1 ms at 50 MHz)
EDGE_MODE, 0, edge type that sets capture bits: 0 rising, 1 falling, 2 both

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
in_port  in  WIDTH  raw asynchronous switch inputs
irq  out  1  interrupt, active-high level

Behaviour:
- Reset (asynchronous, reset_n=0): synchroniser flops, debounced state, counters, irqmask, edgecapture, readdata and irq all go to 0. Reset asserted mid-debounce discards the partial count.
- Synchroniser: in_port passes through SYNC_STAGES flops per bit. Sync output is s[i].
- Debounce, per bit:
  - Counter cnt width is clog2(DEBOUNCE_CYCLES+1).
  - When s[i]==deb[i], cnt clears to 0.
  - Otherwise cnt increments.
  - When cnt reaches DEBOUNCE_CYCLES-1 while still differing, deb[i] takes s[i] on that edge and cnt clears.
  - Result: deb changes exactly DEBOUNCE_CYCLES cycles after s becomes stable.
  - A glitch shorter than DEBOUNCE_CYCLES never changes deb.
- Edge detect: rise[i] = deb[i] & ~deb_d[i]; fall[i] = ~deb[i] & deb_d[i]. deb_d is deb delayed one cycle and resets to 0. An input high at reset therefore produces one rising edge after debounce.
- Register map (read latency 1: readdata valid the cycle after chipselect with write_n=1; readdata updates every cycle from the address mux, as in the existing PIO):
  - 0: data, RO = deb zero-extended to 32. Writes ignored.
  - 1: reserved, reads 0, writes ignored.
  - 2: irqmask, RW, bits [WIDTH-1:0]. Upper bits read 0.
  - 3: edgecapture, RW1C. A write of 1 to bit i clears it; 0 leaves it.
- Edgecapture set: bit i sets on the selected edge per EDGE_MODE. Set dominates clear when an edge and a W1C to the same bit occur in the same cycle.
- irq is registered: irq <= |(edgecapture & irqmask), one cycle after the capture or mask update. Clearing the last enabled capture bit drops irq one cycle after the write.
- Writing irqmask while captures are pending asserts irq on the following cycle.

Decomposition:
- Package sw_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3
  - EDGE_MODE encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2
- One sub-module, sw_debounce: single-bit synchroniser plus debounce counter, parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated WIDTH times with generate.
- The top level holds edge detect, registers, read mux and irq.

Test Plan:
- Reset: hold reset_n=0 with in_port=4'hF, release -> readdata=0, irq=0 after release. Addr 0 reads 4'hF exactly SYNC_STAGES+DEBOUNCE_CYCLES(+1 read) cycles later. edgecapture reads 4'hF (EDGE_MODE=0).
- Glitch rejection (DEBOUNCE_CYCLES=8): pulse in_port[1] high for 7 cycles -> data and edgecapture stay 0. An 8-cycle pulse sets data[1] at the expected cycle.
- IRQ path: irqmask=4'b0100, toggle in_port[2] 0->1 -> edgecapture=4'b0100, irq=1. Write 4'b0100 to addr 3 -> edgecapture=0 and irq=0 one cycle later.
- Masking: edge on bit 0 with irqmask=0 -> irq stays 0. Later write irqmask=1 -> irq rises next cycle.
- Simultaneous set/clear: debounced edge on bit 3 in the same cycle as a W1C of bit 3 -> bit 3 remains 1.
- EDGE_MODE=2, WIDTH=8: press and release in_port[7] -> capture set on each edge. Reserved address 1 reads 0. Upper readdata bits are always 0.
